ghost_chaser: RTL and testbench

- One ghost's movement controller: the counterpart to the Pac-Man movement block on the Kill/position interface.
- Consumes Pac-Man's position (BallX/BallY), steers the ghost through the maze one pixel per frame and produces the Kill signal that freezes Pac-Man.
- Wall sensing uses four externally instantiated pacman_wall_collision probes at GhostX±Ghost_Size / GhostY±Ghost_Size, fed back as Ghost_No_Move.

---
 rtl/ghost_chaser.sv | 178 +++++++++++++++++
 tb/tb_ghost_chaser.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ghost_chaser.sv
// Single-ghost movement controller: cage hold, cage exit, chase/scatter steering
// toward a target with wall avoidance, tunnel wrap and the registered Kill flag.
module ghost_chaser #(
  parameter int Ghost_X_Start  = 320,
  parameter int Ghost_Y_Start  = 240,
  parameter int Exit_Y         = 206,
  parameter int Cage_Frames    = 120,
  parameter int Chase_Frames   = 600,
  parameter int Scatter_Frames = 180,
  parameter int Scatter_X      = 136,
  parameter int Scatter_Y      = 40,
  parameter int Kill_Dist      = 6,
  parameter int Ghost_Size     = 8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [3:0] Ghost_No_Move,
  output logic [9:0] GhostX,
  output logic [9:0] GhostY,
  output logic [9:0] GhostS,
  output logic [1:0] Ghost_Dir,
  output logic [2:0] Ghost_Mode,
  output logic       Kill
);

  localparam int DATA_W = 10;
  localparam logic [DATA_W-1:0] WRAP_LO = 10'd120;
  localparam logic [DATA_W-1:0] WRAP_HI = 10'd520;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    CAGED   = 3'd0,
    EXIT    = 3'd1,
    CHASE   = 3'd2,
    SCATTER = 3'd3,
    CAUGHT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [1:0]        dir_q, dir_d;
  logic              kill_q, kill_d;

  logic [DATA_W-1:0]        tx, ty;
  logic signed [DATA_W:0]   dx, dy, kdx, kdy;
  logic [DATA_W:0]          adx, ady;
  logic [1:0]               pri, sec, rev, mv_dir;
  logic                     mv_en, near, mode_switch;

  function automatic logic [DATA_W:0] abs11(input logic signed [DATA_W:0] v);
    return v[DATA_W] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Ghost_No_Move is packed {up,down,left,right}, so direction d maps to bit 3-d.
  function automatic logic is_blocked(input logic [3:0] nm, input logic [1:0] d);
    return nm[2'd3 - d];
  endfunction

  always_comb begin
    tx  = (state_q == SCATTER) ? 10'(Scatter_X) : BallX;
    ty  = (state_q == SCATTER) ? 10'(Scatter_Y) : BallY;
    dx  = $signed({1'b0, tx}) - $signed({1'b0, x_q});
    dy  = $signed({1'b0, ty}) - $signed({1'b0, y_q});
    kdx = $signed({1'b0, BallX}) - $signed({1'b0, x_q});
    kdy = $signed({1'b0, BallY}) - $signed({1'b0, y_q});
    adx = abs11(dx);
    ady = abs11(dy);
    rev = dir_q ^ 2'b01;

    if (adx >= ady) begin
      pri = dx[DATA_W] ? DIR_LEFT : DIR_RIGHT;
      sec = dy[DATA_W] ? DIR_UP   : DIR_DOWN;
    end else begin
      pri = dy[DATA_W] ? DIR_UP   : DIR_DOWN;
      sec = dx[DATA_W] ? DIR_LEFT : DIR_RIGHT;
    end

    // Reversing is only a last resort; current direction is never its own reverse.
    mv_en  = 1'b1;
    mv_dir = pri;
    if (dx == '0 && dy == '0)                              mv_en  = 1'b0;
    else if (pri != rev && !is_blocked(Ghost_No_Move, pri)) mv_dir = pri;
    else if (sec != rev && !is_blocked(Ghost_No_Move, sec)) mv_dir = sec;
    else if (!is_blocked(Ghost_No_Move, dir_q))             mv_dir = dir_q;
    else if (!is_blocked(Ghost_No_Move, rev))               mv_dir = rev;
    else                                                    mv_en  = 1'b0;

    near = (abs11(kdx) <= 11'(Kill_Dist)) && (abs11(kdy) <= 11'(Kill_Dist));
    mode_switch = (state_q == CHASE   && cnt_q == 10'(Chase_Frames - 1)) ||
                  (state_q == SCATTER && cnt_q == 10'(Scatter_Frames - 1));

    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    kill_d  = kill_q;

    unique case (state_q)
      CAGED: begin
        if (cnt_q == 10'(Cage_Frames - 1)) begin
          state_d = EXIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      EXIT: begin
        y_d   = y_q - 10'd1;
        dir_d = DIR_UP;
        if (y_q == 10'(Exit_Y + 1)) begin
          state_d = CHASE;
          cnt_d   = '0;
        end
      end
      CHASE, SCATTER: begin
        if (near) begin
          kill_d  = 1'b1;
          state_d = CAUGHT;
        end else if (mode_switch) begin
          state_d = (state_q == CHASE) ? SCATTER : CHASE;
          cnt_d   = '0;
          dir_d   = rev;
        end else begin
          cnt_d = cnt_q + 10'd1;
          if (x_q < WRAP_LO)      x_d = WRAP_HI;
          else if (x_q > WRAP_HI) x_d = WRAP_LO;
          else if (mv_en) begin
            dir_d = mv_dir;
            case (mv_dir)
              DIR_UP:   y_d = y_q - 10'd1;
              DIR_DOWN: y_d = y_q + 10'd1;
              DIR_LEFT: x_d = x_q - 10'd1;
              default:  x_d = x_q + 10'd1;
            endcase
          end
        end
      end
      CAUGHT: begin
      end
      default: state_d = CAGED;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= CAGED;
      cnt_q   <= '0;
      x_q     <= 10'(Ghost_X_Start);
      y_q     <= 10'(Ghost_Y_Start);
      dir_q   <= DIR_UP;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      kill_q  <= kill_d;
    end
  end

  assign GhostX     = x_q;
  assign GhostY     = y_q;
  assign GhostS     = 10'(Ghost_Size);
  assign Ghost_Dir  = dir_q;
  assign Ghost_Mode = state_q;
  assign Kill       = kill_q;

endmodule

// File: tb/tb_ghost_chaser.sv
// Directed bench for ghost_chaser: cage/exit timing, steering, mode switches,
// tunnel wrap, kill/caught behaviour and reset from every phase.
module tb_ghost_chaser;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [9:0] BallX, BallY;
  logic [3:0] Ghost_No_Move;
  logic [9:0] GhostX, GhostY, GhostS;
  logic [1:0] Ghost_Dir;
  logic [2:0] Ghost_Mode;
  logic       Kill;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 frame_clk = ~frame_clk;

  ghost_chaser dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .BallX        (BallX),
    .BallY        (BallY),
    .Ghost_No_Move(Ghost_No_Move),
    .GhostX       (GhostX),
    .GhostY       (GhostY),
    .GhostS       (GhostS),
    .Ghost_Dir    (Ghost_Dir),
    .Ghost_Mode   (Ghost_Mode),
    .Kill         (Kill)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"},    int'(GhostX), 320);
    chk({tag, "_y"},    int'(GhostY), 240);
    chk({tag, "_kill"}, int'(Kill), 0);
    chk({tag, "_mode"}, int'(Ghost_Mode), 0);
    chk({tag, "_dir"},  int'(Ghost_Dir), 0);
  endtask

  initial begin
    int bad;
    Reset = 1'b1;
    BallX = 10'd400;
    BallY = 10'd210;
    Ghost_No_Move = 4'b0000;
    tick(1);
    chk_reset_state("rst0");
    chk("ghost_s", int'(GhostS), 8);
    Reset = 1'b0;

    // Caged for 120 frames, then exit upward.
    bad = 0;
    for (int i = 0; i < 119; i++) begin
      tick(1);
      if (GhostY != 10'd240 || Ghost_Mode != 3'd0 || GhostX != 10'd320) bad++;
    end
    chk("caged_hold", bad, 0);
    tick(1);
    chk("exit_mode", int'(Ghost_Mode), 1);
    chk("exit_y0", int'(GhostY), 240);
    bad = 0;
    for (int i = 0; i < 33; i++) begin
      tick(1);
      if (GhostY != 10'(239 - i) || Ghost_Mode != 3'd1 || GhostX != 10'd320 || Ghost_Dir != 2'd0) bad++;
    end
    chk("exit_walk", bad, 0);
    tick(1);
    chk("chase_entry_mode", int'(Ghost_Mode), 2);
    chk("chase_entry_y", int'(GhostY), 206);
    chk("chase_entry_x", int'(GhostX), 320);

    // Steering: right toward the ball, then down when right is walled.
    tick(1);
    chk("step_right_x", int'(GhostX), 321);
    chk("step_right_dir", int'(Ghost_Dir), 3);
    Ghost_No_Move = 4'b0001;
    tick(1);
    chk("step_down_dir", int'(Ghost_Dir), 1);
    chk("step_down_y", int'(GhostY), 207);
    chk("step_down_x", int'(GhostX), 321);

    // Boxed in until the CHASE period expires.
    Ghost_No_Move = 4'b1111;
    tick(597);
    chk("chase_hold_mode", int'(Ghost_Mode), 2);
    chk("boxed_x", int'(GhostX), 321);
    chk("boxed_y", int'(GhostY), 207);
    tick(1);
    chk("scatter_mode", int'(Ghost_Mode), 3);
    chk("scatter_rev_dir", int'(Ghost_Dir), 0);
    chk("scatter_sw_x", int'(GhostX), 321);
    chk("scatter_sw_y", int'(GhostY), 207);

    // Scatter target (136,40) lies mostly left.
    Ghost_No_Move = 4'b0000;
    tick(1);
    chk("scatter_step_x", int'(GhostX), 320);
    chk("scatter_step_dir", int'(Ghost_Dir), 2);
    Ghost_No_Move = 4'b1111;
    tick(178);
    chk("scatter_hold_mode", int'(Ghost_Mode), 3);
    tick(1);
    chk("chase_again_mode", int'(Ghost_Mode), 2);
    chk("chase_again_dir", int'(Ghost_Dir), 3);

    // Only left open: reverse is taken as last resort, then the tunnel wrap.
    BallX = 10'd100;
    BallY = 10'd207;
    Ghost_No_Move = 4'b1101;
    tick(1);
    chk("last_resort_x", int'(GhostX), 319);
    chk("last_resort_dir", int'(Ghost_Dir), 2);
    tick(199);
    chk("walk_x120", int'(GhostX), 120);
    tick(1);
    chk("walk_x119", int'(GhostX), 119);
    tick(1);
    chk("wrap_520", int'(GhostX), 520);
    chk("wrap_dir", int'(Ghost_Dir), 2);
    tick(1);
    chk("after_wrap", int'(GhostX), 519);
    tick(219);
    chk("mid_chase_x", int'(GhostX), 300);
    chk("mid_chase_mode", int'(Ghost_Mode), 2);

    Reset = 1'b1;
    tick(1);
    chk_reset_state("rst_chase");
    Reset = 1'b0;

    // Ball sits on the ghost through cage and exit: no kill there.
    BallX = 10'd320;
    BallY = 10'd240;
    Ghost_No_Move = 4'b0000;
    bad = 0;
    for (int i = 0; i < 154; i++) begin
      if (i == 130) BallY = 10'd215;
      tick(1);
      if (Kill != 1'b0) bad++;
    end
    chk("no_kill_cage_exit", bad, 0);
    chk("kill_run_mode", int'(Ghost_Mode), 2);
    chk("kill_run_y", int'(GhostY), 206);

    BallX = 10'd325;
    BallY = 10'd211;
    tick(1);
    chk("kill_set", int'(Kill), 1);
    chk("caught_mode", int'(Ghost_Mode), 4);
    chk("caught_x", int'(GhostX), 320);
    chk("caught_y", int'(GhostY), 206);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      BallX = 10'(200 + 3 * i);
      BallY = 10'(100 + 2 * i);
      Ghost_No_Move = 4'(i);
      tick(1);
      if (Kill != 1'b1 || Ghost_Mode != 3'd4 || GhostX != 10'd320 || GhostY != 10'd206 || Ghost_Dir != 2'd0) bad++;
    end
    chk("caught_frozen", bad, 0);

    Reset = 1'b1;
    tick(1);
    chk_reset_state("rst_caught");
    Reset = 1'b0;
    tick(1);
    chk("post_reset_mode", int'(Ghost_Mode), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
